timer_ctrl_gen: RTL and testbench

Parametrised next-generation stopwatch/timer control FSM. It merges debounced push-button levels and UART command bytes into one command stream. It drives a multi-field timer datapath with per-field increment/decrement strobes, held-button auto-repeat, count-direction mode, and auto-stop on terminal count. It sits between the button debouncers / UART RX FIFO and the timer counter datapath.

---
 rtl/timer_ctrl_pkg.sv | 46 ++++
 rtl/timer_repeat_cnt.sv | 28 ++
 rtl/timer_ctrl_gen.sv | 178 +++++++++++++++++
 tb/tb_timer_ctrl_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared encodings for the stopwatch/timer control FSM: states, UART command bytes
// and the command priority used to arbitrate coincident events.
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP   = 2'd0,
    RUN    = 2'd1,
    HOLD_U = 2'd2,
    HOLD_D = 2'd3
  } state_t;

  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_U = 8'h55;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_F = 8'h46;
  localparam logic [7:0] CMD_M = 8'h4D;
  localparam logic [7:0] CMD_S = 8'h53;

  typedef enum logic [3:0] {
    PRI_NONE = 4'd0,
    PRI_S    = 4'd1,
    PRI_TC   = 4'd2,
    PRI_R    = 4'd3,
    PRI_L    = 4'd4,
    PRI_U    = 4'd5,
    PRI_D    = 4'd6,
    PRI_F    = 4'd7,
    PRI_M    = 4'd8
  } cmd_pri_t;

  function automatic cmd_pri_t pick_cmd(input logic s, input logic t, input logic r,
                                        input logic l, input logic u, input logic d,
                                        input logic f, input logic m);
    if (s) return PRI_S;
    if (t) return PRI_TC;
    if (r) return PRI_R;
    if (l) return PRI_L;
    if (u) return PRI_U;
    if (d) return PRI_D;
    if (f) return PRI_F;
    if (m) return PRI_M;
    return PRI_NONE;
  endfunction

endpackage

// File: rtl/timer_repeat_cnt.sv
// Loadable down-counter for button auto-repeat; expire flags the cycle the count
// sits at zero while enabled, and the owner reloads it in that same cycle.
module timer_repeat_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] r_cnt;

  assign expire = en && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl_gen.sv
// Stopwatch/timer control FSM: merges button edges and UART bytes into one prioritised
// command stream and drives run/clear/inc/dec/done strobes for the counter datapath.
//
// state  | meaning
// STOP   | idle; accepts R, L, U, D, F/C, M
// RUN    | counting; only S, tc (count-down) and R act
// HOLD_U | U button held; auto-repeat inc strobes until release or S
// HOLD_D | D button held; auto-repeat dec strobes until release or S
module timer_ctrl_gen
  import timer_ctrl_pkg::*;
#(
  parameter int NUM_FIELD        = 3,
  parameter int REPEAT_DELAY_CYC = 50_000_000,
  parameter int REPEAT_RATE_CYC  = 10_000_000,
  localparam int FW = (NUM_FIELD > 1) ? $clog2(NUM_FIELD) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_R,
  input  logic                 btn_L,
  input  logic                 btn_U,
  input  logic                 btn_D,
  input  logic                 btn_C,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 tc,
  output logic                 run_stop,
  output logic                 clear,
  output logic [NUM_FIELD-1:0] inc,
  output logic [NUM_FIELD-1:0] dec,
  output logic [FW-1:0]        field_sel,
  output logic                 count_dir,
  output logic                 done
);

  localparam int MAXC = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  state_t                r_state;
  logic [4:0]            r_btn_q;
  logic                  r_arm;
  logic                  r_run_stop;
  logic                  r_clear;
  logic                  r_done;
  logic [NUM_FIELD-1:0]  r_inc;
  logic [NUM_FIELD-1:0]  r_dec;
  logic [FW-1:0]         r_field_sel;
  logic                  r_count_dir;

  logic [4:0]            w_btn;
  logic [4:0]            w_rise;
  logic                  w_ev_s, w_ev_tc, w_ev_r, w_ev_l, w_ev_u, w_ev_d, w_ev_f, w_ev_m;
  cmd_pri_t              w_win;
  logic [NUM_FIELD-1:0]  w_onehot;
  logic                  w_hold_btn;
  logic                  w_cnt_en;
  logic                  w_enter_hold;
  logic                  w_cnt_load;
  logic [CW-1:0]         w_cnt_val;
  logic                  w_expire;

  // Bit order {C, D, U, L, R}. Edges are masked in the first cycle after reset so a
  // button already held at reset release never counts as a new press.
  assign w_btn  = {btn_C, btn_D, btn_U, btn_L, btn_R};
  assign w_rise = w_btn & ~r_btn_q & {5{r_arm}};

  assign w_ev_s  = rx_valid && (rx_data == CMD_S);
  assign w_ev_tc = tc && r_count_dir && (r_state == RUN);
  assign w_ev_r  = w_rise[0] || (rx_valid && (rx_data == CMD_R));
  assign w_ev_l  = w_rise[1] || (rx_valid && (rx_data == CMD_L));
  assign w_ev_u  = w_rise[2] || (rx_valid && (rx_data == CMD_U));
  assign w_ev_d  = w_rise[3] || (rx_valid && (rx_data == CMD_D));
  assign w_ev_f  = w_rise[4] || (rx_valid && (rx_data == CMD_F));
  assign w_ev_m  = rx_valid && (rx_data == CMD_M);

  assign w_win = pick_cmd(w_ev_s, w_ev_tc, w_ev_r, w_ev_l, w_ev_u, w_ev_d, w_ev_f, w_ev_m);

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_FIELD; i++) begin
      w_onehot[i] = (r_field_sel == FW'(i));
    end
  end

  assign w_hold_btn   = ((r_state == HOLD_U) && btn_U) || ((r_state == HOLD_D) && btn_D);
  assign w_cnt_en     = w_hold_btn && !w_ev_s;
  assign w_enter_hold = (r_state == STOP) &&
                        (((w_win == PRI_U) && w_rise[2]) || ((w_win == PRI_D) && w_rise[3]));
  assign w_cnt_load   = w_enter_hold || w_expire;
  assign w_cnt_val    = w_enter_hold ? CW'(REPEAT_DELAY_CYC - 1) : CW'(REPEAT_RATE_CYC - 1);

  timer_repeat_cnt #(.W(CW)) u_repeat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .en       (w_cnt_en),
    .expire   (w_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= STOP;
      r_btn_q     <= '0;
      r_arm       <= 1'b0;
      r_run_stop  <= 1'b0;
      r_clear     <= 1'b0;
      r_done      <= 1'b0;
      r_inc       <= '0;
      r_dec       <= '0;
      r_field_sel <= '0;
      r_count_dir <= 1'b0;
    end else begin
      r_btn_q <= w_btn;
      r_arm   <= 1'b1;
      r_clear <= 1'b0;
      r_done  <= 1'b0;
      r_inc   <= '0;
      r_dec   <= '0;
      case (r_state)
        STOP: begin
          case (w_win)
            PRI_R: begin
              r_state    <= RUN;
              r_run_stop <= 1'b1;
            end
            PRI_L: r_clear <= 1'b1;
            PRI_U: begin
              r_inc <= w_onehot;
              if (w_rise[2]) r_state <= HOLD_U;
            end
            PRI_D: begin
              r_dec <= w_onehot;
              if (w_rise[3]) r_state <= HOLD_D;
            end
            PRI_F: begin
              if (r_field_sel == FW'(NUM_FIELD - 1)) r_field_sel <= '0;
              else                                   r_field_sel <= r_field_sel + FW'(1);
            end
            PRI_M:   r_count_dir <= ~r_count_dir;
            default: ;
          endcase
        end
        RUN: begin
          if ((w_win == PRI_S) || (w_win == PRI_R)) begin
            r_state    <= STOP;
            r_run_stop <= 1'b0;
          end else if (w_win == PRI_TC) begin
            r_state    <= STOP;
            r_run_stop <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        HOLD_U, HOLD_D: begin
          if (!w_cnt_en) begin
            r_state <= STOP;
          end else if (w_expire) begin
            if (r_state == HOLD_U) r_inc <= w_onehot;
            else                   r_dec <= w_onehot;
          end
        end
        default: begin
          r_state    <= STOP;
          r_run_stop <= 1'b0;
        end
      endcase
    end
  end

  assign run_stop  = r_run_stop;
  assign clear     = r_clear;
  assign inc       = r_inc;
  assign dec       = r_dec;
  assign field_sel = r_field_sel;
  assign count_dir = r_count_dir;
  assign done      = r_done;

endmodule

// File: tb/tb_timer_ctrl_gen.sv
// Directed bench for timer_ctrl_gen: a one-cycle-per-entry vector table for command
// decode/priority, plus hand sequences for auto-repeat, held C and reset mid-hold.
module tb_timer_ctrl_gen;

  localparam logic [4:0] B_R = 5'b00001;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_U = 5'b00100;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_0 = 5'b00000;
  localparam logic [7:0] RX0 = 8'h00;

  logic       clk, rst;
  logic       btn_R, btn_L, btn_U, btn_D, btn_C;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tc;
  logic       run_stop, clear, count_dir, done;
  logic [2:0] inc, dec;
  logic [1:0] field_sel;

  int n_chk = 0;
  int n_err = 0;

  timer_ctrl_gen #(
    .NUM_FIELD        (3),
    .REPEAT_DELAY_CYC (8),
    .REPEAT_RATE_CYC  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_R     (btn_R),
    .btn_L     (btn_L),
    .btn_U     (btn_U),
    .btn_D     (btn_D),
    .btn_C     (btn_C),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tc        (tc),
    .run_stop  (run_stop),
    .clear     (clear),
    .inc       (inc),
    .dec       (dec),
    .field_sel (field_sel),
    .count_dir (count_dir),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] btn;
    logic [7:0] rx;
    logic       tc;
    logic       run;
    logic       clr;
    logic [2:0] inc;
    logic [2:0] dec;
    logic [1:0] fsel;
    logic       dir;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic [4:0] b, input logic [7:0] rx, input logic t,
                               input logic run, input logic clr, input logic [2:0] i,
                               input logic [2:0] d, input logic [1:0] fs, input logic dir,
                               input logic dn);
    vec_t v;
    v.btn = b; v.rx = rx; v.tc = t; v.run = run; v.clr = clr;
    v.inc = i; v.dec = d; v.fsel = fs; v.dir = dir; v.done = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] b, input logic [7:0] rx, input logic t);
    {btn_C, btn_D, btn_U, btn_L, btn_R} = b;
    rx_valid = (rx != 8'h00);
    rx_data  = rx;
    tc       = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".run"},  32'(run_stop),  32'(v.run));
    chk({tag, ".clr"},  32'(clear),     32'(v.clr));
    chk({tag, ".inc"},  32'(inc),       32'(v.inc));
    chk({tag, ".dec"},  32'(dec),       32'(v.dec));
    chk({tag, ".fsel"}, 32'(field_sel), 32'(v.fsel));
    chk({tag, ".dir"},  32'(count_dir), 32'(v.dir));
    chk({tag, ".done"}, 32'(done),      32'(v.done));
  endtask

  initial begin
    //            btn  rx     tc   run  clr  inc     dec     fs  dir done
    vecs.push_back(mkv(B_0, RX0,   0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mkv(B_R, RX0,   0, 1, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mkv(B_R, RX0,   0, 1, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mkv(B_0, "R",   0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mkv(B_0, "M",   0, 0, 0, 3'b000, 3'b000, 0, 1, 0));
    vecs.push_back(mkv(B_0, "R",   0, 1, 0, 3'b000, 3'b000, 0, 1, 0));
    vecs.push_back(mkv(B_0, RX0,   1, 0, 0, 3'b000, 3'b000, 0, 1, 1));
    vecs.push_back(mkv(B_0, RX0,   1, 0, 0, 3'b000, 3'b000, 0, 1, 0));
    vecs.push_back(mkv(B_0, "M",   0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mkv(B_0, "R",   0, 1, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mkv(B_0, RX0,   1, 1, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mkv(B_0, "R",   1, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mkv(B_0, "F",   0, 0, 0, 3'b000, 3'b000, 1, 0, 0));
    vecs.push_back(mkv(B_0, "F",   0, 0, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, "F",   0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    vecs.push_back(mkv(B_0, "F",   0, 0, 0, 3'b000, 3'b000, 1, 0, 0));
    vecs.push_back(mkv(B_C, RX0,   0, 0, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_C, RX0,   0, 0, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, RX0,   0, 0, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_L, "U",   0, 0, 1, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, RX0,   0, 0, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, "U",   0, 0, 0, 3'b100, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, RX0,   0, 0, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, "D",   0, 0, 0, 3'b000, 3'b100, 2, 0, 0));
    vecs.push_back(mkv(B_0, "M",   0, 0, 0, 3'b000, 3'b000, 2, 1, 0));
    vecs.push_back(mkv(B_0, "R",   0, 1, 0, 3'b000, 3'b000, 2, 1, 0));
    vecs.push_back(mkv(B_0, "S",   1, 0, 0, 3'b000, 3'b000, 2, 1, 0));
    vecs.push_back(mkv(B_0, "X",   0, 0, 0, 3'b000, 3'b000, 2, 1, 0));
    vecs.push_back(mkv(B_0, "M",   0, 0, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_R, "L",   0, 1, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, "S",   0, 0, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, "R",   0, 1, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, "L",   0, 1, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, "U",   0, 1, 0, 3'b000, 3'b000, 2, 0, 0));
    vecs.push_back(mkv(B_0, "S",   0, 0, 0, 3'b000, 3'b000, 2, 0, 0));

    rst = 1'b0;
    drive(B_0, RX0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", mkv(B_0, RX0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    #2 rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].btn, vecs[i].rx, vecs[i].tc);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // U held 20 cycles at field 2; stray "D" mid-hold must be ignored
    for (int k = 1; k <= 25; k++) begin
      drive(((k - 1) <= 19) ? B_U : B_0, (k == 5) ? 8'h44 : RX0, 1'b0);
      tick();
      chk($sformatf("hold_u.inc@%0d", k), 32'(inc),
          ((k == 1) || (k == 9) || (k == 12) || (k == 15) || (k == 18)) ? 32'h4 : 32'h0);
      chk($sformatf("hold_u.dec@%0d", k), 32'(dec), 32'h0);
    end

    // C held 10 cycles advances the field once (2 -> 0)
    for (int k = 1; k <= 10; k++) begin
      drive(B_C, RX0, 1'b0);
      tick();
      chk($sformatf("hold_c.fsel@%0d", k), 32'(field_sel), 32'h0);
    end
    drive(B_0, RX0, 1'b0);
    tick();
    chk("hold_c.release", 32'(field_sel), 32'h0);

    drive(B_0, "F", 1'b0); tick();
    drive(B_0, "M", 1'b0); tick();
    chk("pre_rst.fsel", 32'(field_sel), 32'h1);
    chk("pre_rst.dir",  32'(count_dir), 32'h1);

    drive(B_D, RX0, 1'b0);
    tick();
    chk("hold_d.first", 32'(dec), 32'h2);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    chk_all("rst_mid_hold", mkv(B_0, RX0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0));
    @(posedge clk);
    #3 rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("post_rst.dec@%0d", k), 32'(dec), 32'h0);
    end
    drive(B_0, RX0, 1'b0);
    tick();
    drive(B_D, RX0, 1'b0);
    tick();
    chk("repress_d.dec", 32'(dec), 32'h1);
    drive(B_0, RX0, 1'b0);
    tick();
    chk("release_d.dec", 32'(dec), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
